// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared types and constants for the APB3 requester (apb_master).
//   apb_mst_state_e : transfer sequencer states
//   apb_req_t       : command fields at default widths
//   apb_rsp_t       : response fields at default widths
//   wait_cnt_width  : width of the PREADY watchdog counter for a given timeout
// -----------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_ADDR_WIDTH_DEF = 9;
  localparam int APB_DATA_WIDTH_DEF = 32;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  typedef struct packed {
    logic                          write;
    logic [APB_ADDR_WIDTH_DEF-1:0] addr;
    logic [APB_DATA_WIDTH_DEF-1:0] wdata;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_WIDTH_DEF-1:0] rdata;
    logic                          err;
    logic                          timeout;
  } apb_rsp_t;

  // Counter must hold 0..TIMEOUT_CYCLES-1; a disabled watchdog still needs 1 bit.
  function automatic int wait_cnt_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 32'sd1);
    if (w < 32'sd1) begin
      w = 32'sd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
// APB3 requester: accepts one command at a time on a valid/ready port, runs it
// as an APB SETUP/ACCESS transfer and returns the result on a valid/ready
// response port. A watchdog aborts ACCESS phases that PREADY stalls for too
// long (TIMEOUT_CYCLES = 0 disables it).
//
// Ports
//   HCLK, HRESET                  clock, asynchronous active-high reset
//   req_valid/req_ready           command handshake
//   req_write/req_addr/req_wdata  command fields
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata/rsp_err/rsp_timeout response fields (rdata 0 for writes/timeouts)
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE  APB requester outputs
//   PRDATA/PREADY/PSLVERR             APB completer inputs
// -----------------------------------------------------------------------------
module apb_master
  import apb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = APB_ADDR_WIDTH_DEF,
  parameter int APB_DATA_WIDTH = APB_DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATA_WIDTH-1:0] PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int CNT_W = wait_cnt_width(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 32'sd0);
  // Last counter value before the watchdog fires (unused when disabled).
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TO_EN ? (TIMEOUT_CYCLES - 32'sd1) : 32'sd0);

  apb_mst_state_e state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      req_ready_q, req_ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      rsp_timeout_q, rsp_timeout_d;

  // Next-state, captured command/response fields and output decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
          pwrite_d = req_write;
          state_d  = SETUP;
        end else begin
          state_d  = IDLE;
        end
      end
      SETUP: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ACCESS;
      end
      ACCESS: begin
        // PREADY wins over a watchdog expiry in the same cycle.
        if (PREADY) begin
          rsp_rdata_d   = pwrite_q ? {APB_DATA_WIDTH{1'b0}} : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          rsp_rdata_d   = {APB_DATA_WIDTH{1'b0}};
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else if (TO_EN) begin
          cnt_d         = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d       = ACCESS;
        end else begin
          state_d       = ACCESS;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they change with it.
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // State and output registers; reset clears APB strobes immediately.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q       <= IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      paddr_q       <= {APB_ADDR_WIDTH{1'b0}};
      pwdata_q      <= {APB_DATA_WIDTH{1'b0}};
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= {APB_DATA_WIDTH{1'b0}};
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PWRITE      = pwrite_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
// Self-checking bench for apb_master: directed and random transfers against a
// transaction-level reference, plus reset and disabled-watchdog scenarios.
// -----------------------------------------------------------------------------
module tb_apb_master;
  import apb_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          HCLK = 1'b0;
  logic          HRESET;
  always #5 HCLK = ~HCLK;

  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

  logic          nt_req_valid, nt_req_ready, nt_req_write;
  logic [AW-1:0] nt_req_addr;
  logic [DW-1:0] nt_req_wdata;
  logic          nt_rsp_valid, nt_rsp_ready, nt_rsp_err, nt_rsp_timeout;
  logic [DW-1:0] nt_rsp_rdata;
  logic [AW-1:0] nt_paddr;
  logic [DW-1:0] nt_pwdata, nt_prdata;
  logic          nt_pwrite, nt_psel, nt_penable, nt_pready, nt_pslverr;

  apb_master #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) u_dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_master #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) u_dut_nt (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(nt_req_valid), .req_ready(nt_req_ready), .req_write(nt_req_write),
    .req_addr(nt_req_addr), .req_wdata(nt_req_wdata),
    .rsp_valid(nt_rsp_valid), .rsp_ready(nt_rsp_ready), .rsp_rdata(nt_rsp_rdata),
    .rsp_err(nt_rsp_err), .rsp_timeout(nt_rsp_timeout),
    .PADDR(nt_paddr), .PWDATA(nt_pwdata), .PWRITE(nt_pwrite), .PSEL(nt_psel),
    .PENABLE(nt_penable), .PRDATA(nt_prdata), .PREADY(nt_pready), .PSLVERR(nt_pslverr)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic apb_req_t mk_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    apb_req_t r;
    r.write = w;
    r.addr  = a;
    r.wdata = d;
    return r;
  endfunction

  // Transaction-level reference: the completer raises PREADY after `waits`
  // stalled ACCESS cycles; the watchdog wins if that would exceed TO cycles.
  function automatic apb_rsp_t model_rsp(input apb_req_t r, input int waits,
                                         input logic [DW-1:0] prd, input logic slv,
                                         output int acc);
    apb_rsp_t s;
    if (TO != 0 && waits >= TO) begin
      s.rdata = '0; s.err = 1'b1; s.timeout = 1'b1; acc = TO;
    end else begin
      s.rdata = r.write ? '0 : prd; s.err = slv; s.timeout = 1'b0; acc = waits + 1;
    end
    return s;
  endfunction

  // One full transfer: command, APB completer behaviour, response with backpressure.
  task automatic run_op(input apb_req_t r, input int waits, input logic [DW-1:0] prd,
                        input logic slv, input int bp);
    apb_rsp_t e;
    int acc_exp;
    int acc;
    e = model_rsp(r, waits, prd, slv, acc_exp);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_psel", PSEL, 0);
    req_valid = 1'b1; req_write = r.write; req_addr = r.addr; req_wdata = r.wdata;
    @(posedge HCLK); #1;
    req_valid = 1'b0; req_write = $urandom; req_addr = $urandom; req_wdata = $urandom;
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_paddr", PADDR, r.addr);
    chk("setup_pwdata", PWDATA, r.wdata);
    chk("setup_pwrite", PWRITE, r.write);
    chk("setup_req_ready", req_ready, 0);
    @(posedge HCLK); #1;
    acc = 0;
    while (PSEL && acc < 200) begin
      chk("access_penable", PENABLE, 1);
      chk("access_paddr", PADDR, r.addr);
      chk("access_pwdata", PWDATA, r.wdata);
      chk("access_pwrite", PWRITE, r.write);
      chk("access_rsp_valid", rsp_valid, 0);
      PREADY  = (acc == waits);
      PRDATA  = (acc == waits) ? prd : $urandom;
      PSLVERR = (acc == waits) ? slv : 1'($urandom);
      acc++;
      @(posedge HCLK); #1;
    end
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
    chk("access_cycles", acc, acc_exp);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_penable", PENABLE, 0);
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_err", rsp_err, e.err);
    chk("rsp_timeout", rsp_timeout, e.timeout);
    repeat (bp) begin
      @(posedge HCLK); #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, e.rdata);
      chk("bp_rsp_err", rsp_err, e.err);
      chk("bp_rsp_timeout", rsp_timeout, e.timeout);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_psel", PSEL, 0);
    end
    rsp_ready = 1'b1;
    @(posedge HCLK); #1;
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
    chk("post_psel", PSEL, 0);
  endtask

  initial begin
    apb_req_t r;
    HRESET = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    nt_req_valid = 1'b0; nt_req_write = 1'b0; nt_req_addr = '0; nt_req_wdata = '0;
    nt_rsp_ready = 1'b0; nt_prdata = '0; nt_pready = 1'b0; nt_pslverr = 1'b0;

    // Reset state
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_req_ready", req_ready, 1);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // Directed transfers
    run_op(mk_req(1'b1, 9'h004, 32'h0000_00FF), 0, 32'h0, 1'b0, 0);
    run_op(mk_req(1'b0, 9'h008, 32'h0),         3, 32'hDEAD_BEEF, 1'b0, 0);
    run_op(mk_req(1'b0, 9'h1FC, 32'h0),         0, 32'h1234_5678, 1'b1, 0);
    run_op(mk_req(1'b0, 9'h010, 32'h0),      1000, 32'hCAFE_F00D, 1'b0, 0);
    run_op(mk_req(1'b0, 9'h014, 32'h0),        15, 32'h0BAD_CAFE, 1'b0, 0);
    run_op(mk_req(1'b0, 9'h018, 32'h0),        16, 32'h0BAD_CAFE, 1'b0, 0);
    run_op(mk_req(1'b1, 9'h020, 32'hA5A5_5A5A), 0, 32'h5555_AAAA, 1'b0, 5);

    // Random transfers
    for (int i = 0; i < 24; i++) begin
      r = mk_req(1'($urandom), AW'($urandom), $urandom);
      run_op(r, int'($urandom_range(0, 20)), $urandom, 1'($urandom), int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of an ACCESS phase
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h030; req_wdata = 32'h0;
    @(posedge HCLK); #1;
    req_valid = 1'b0;
    @(posedge HCLK); #1;
    chk("pre_rst_penable", PENABLE, 1);
    #3;
    HRESET = 1'b1;
    #1;
    chk("arst_psel", PSEL, 0);
    chk("arst_penable", PENABLE, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_req_ready", req_ready, 1);
    @(negedge HCLK);
    HRESET = 1'b0;
    repeat (3) begin
      @(posedge HCLK); #1;
      chk("after_rst_rsp_valid", rsp_valid, 0);
      chk("after_rst_psel", PSEL, 0);
      chk("after_rst_req_ready", req_ready, 1);
    end
    run_op(mk_req(1'b0, 9'h034, 32'h0), 1, 32'h0F0F_0F0F, 1'b0, 0);

    // Watchdog disabled: a stalled transfer never completes
    chk("nt_req_ready", nt_req_ready, 1);
    nt_req_valid = 1'b1; nt_req_addr = 9'h040;
    @(posedge HCLK); #1;
    nt_req_valid = 1'b0;
    chk("nt_setup_psel", nt_psel, 1);
    chk("nt_setup_penable", nt_penable, 0);
    repeat (100) begin
      @(posedge HCLK); #1;
      chk("nt_stall_rsp_valid", nt_rsp_valid, 0);
      chk("nt_stall_psel", nt_psel, 1);
      chk("nt_stall_penable", nt_penable, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
